pipe_stall_ctrl: RTL

//  Replaces the constant-zero pipeline stall controller in mycpu_core. Merges the ID load-use stall request

---
 rtl/pipe_stall_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Pipeline stall controller. Merges the ID load-use request
//               with a sequencer for the iterative EX divider.
//               Optional perf counters: define STALL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int STALL_W     = 6,
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               ex_div_req,
    input  logic               ex_div_zero,
    input  logic               div_done,
    output logic               div_start,
    output logic               div_result_we,
    output logic               div_abort,
`ifdef STALL_PERF_CNT_EN
    output logic [31:0]        perf_div_stall,
    output logic [31:0]        perf_lu_stall,
`endif
    output logic [STALL_W-1:0] stall
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_busy  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [STALL_W-1:0] c_stall_div = STALL_W'(4'b1111);
    localparam logic [STALL_W-1:0] c_stall_lu  = STALL_W'(3'b111);
    localparam logic [CNT_W-1:0]   c_cnt_last  = CNT_W'(DIV_TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_div_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        div_start     = 1'b0;
        div_result_we = 1'b0;
        div_abort     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (ex_div_req)
                    w_state_next = ex_div_zero ? c_st_done : c_st_start;
            end
            c_st_start: begin
                // A vanished request is aborted rather than launched
                if (!ex_div_req) begin
                    div_abort    = 1'b1;
                    w_state_next = c_st_idle;
                end else begin
                    div_start    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = c_st_busy;
                end
            end
            c_st_busy: begin
                if (r_cnt != c_cnt_last)
                    w_cnt_next = r_cnt + CNT_W'(1);
                if (!ex_div_req) begin
                    div_abort    = 1'b1;
                    w_state_next = c_st_idle;
                end else if (div_done) begin
                    w_state_next = c_st_done;
                end else if (r_cnt == c_cnt_last) begin
                    div_abort    = 1'b1;
                    w_state_next = c_st_idle;
                end
            end
            c_st_done: begin
                div_result_we = 1'b1;
                w_state_next  = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // IDLE term lets the stall land in the same cycle the divide appears in EX
    assign w_div_busy = (r_state == c_st_start) || (r_state == c_st_busy) ||
                        ((r_state == c_st_idle) && ex_div_req && !ex_div_zero);

    assign stall = w_div_busy  ? c_stall_div :
                   stallreq_id ? c_stall_lu  : '0;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_perf_div;
    logic [31:0] r_perf_lu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_div <= '0;
            r_perf_lu  <= '0;
        end else begin
            if (stall == c_stall_div)
                r_perf_div <= r_perf_div + 32'd1;
            if (stall == c_stall_lu)
                r_perf_lu <= r_perf_lu + 32'd1;
        end
    end

    assign perf_div_stall = r_perf_div;
    assign perf_lu_stall  = r_perf_lu;
`endif

endmodule
`default_nettype wire
